// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO arbiter: operation encoding and the
// round-robin writer selection helper.
package fifo_arb_pkg;

  localparam int MAX_REQ = 8;

  localparam logic [1:0] OP_NONE  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;

  // First valid index strictly after ptr, wrapping modulo n; returns ptr if none valid.
  function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] valid,
                                          input int unsigned ptr,
                                          input int unsigned n);
    int unsigned pick;
    int unsigned idx;
    logic        found;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned k = 1; k <= MAX_REQ; k++) begin
      idx = (ptr + k) % n;
      if (!found && (k <= n) && valid[idx[2:0]]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/fifo.sv
// Circular-buffer FIFO with a registered head output. The occupancy
// count handles either a write or a read per cycle, not both.
module fifo #(
  parameter int ITEM_SIZE_BITS = 32,
  parameter int FIFO_SIZE      = 10
) (
  input  logic                         CLOCK_50,
  input  logic                         RST_N,
  input  logic                         write,
  input  logic                         read,
  input  logic [ITEM_SIZE_BITS-1:0]    data_in,
  output logic [ITEM_SIZE_BITS-1:0]    data_out,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(FIFO_SIZE)-1:0] count
);
  localparam int PW = $clog2(FIFO_SIZE);

  logic [ITEM_SIZE_BITS-1:0] r_mem [FIFO_SIZE];
  logic [PW-1:0]             r_wr_ptr;
  logic [PW-1:0]             r_rd_ptr;
  logic [PW-1:0]             r_count;
  logic [ITEM_SIZE_BITS-1:0] r_data_out;
  logic                      w_do_wr;
  logic                      w_do_rd;

  assign full     = (r_count == PW'(FIFO_SIZE));
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign data_out = r_data_out;
  assign w_do_wr  = write && !full;
  assign w_do_rd  = read && !write && !empty;

  always_ff @(posedge CLOCK_50) begin
    if (w_do_wr) r_mem[r_wr_ptr] <= data_in;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RST_N) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_data_out <= '0;
    end else if (w_do_wr) begin
      r_wr_ptr <= (r_wr_ptr == PW'(FIFO_SIZE - 1)) ? '0 : r_wr_ptr + 1'b1;
      r_count  <= r_count + 1'b1;
    end else if (w_do_rd) begin
      r_data_out <= r_mem[r_rd_ptr];
      r_rd_ptr   <= (r_rd_ptr == PW'(FIFO_SIZE - 1)) ? '0 : r_rd_ptr + 1'b1;
      r_count    <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/fifo_arbiter.sv
// Round-robin arbiter sharing one fifo between NUM_REQ writers and one reader;
// issues at most one fifo operation per cycle, alternating under contention.
module fifo_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int ITEM_SIZE_BITS = 32,
  parameter int FIFO_SIZE      = 10,
  parameter int NUM_REQ        = 4
) (
  input  logic                               CLOCK_50,
  input  logic                               RST_N,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ*ITEM_SIZE_BITS-1:0]  req_data,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic                               out_valid,
  output logic [ITEM_SIZE_BITS-1:0]          out_data,
  input  logic                               out_ready,
  output logic [$clog2(FIFO_SIZE+1)-1:0]     level,
  output logic [$clog2(NUM_REQ)-1:0]         last_grant
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int LW = $clog2(FIFO_SIZE + 1);

  if ((FIFO_SIZE & (FIFO_SIZE - 1)) == 0) begin : g_bad_fifo_size
    $error("fifo_arbiter: FIFO_SIZE must not be a power of two");
  end
  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
    $error("fifo_arbiter: NUM_REQ must be in 2..8");
  end

  logic [GW-1:0]             r_rr_ptr;
  logic [GW-1:0]             r_last_grant;
  logic [1:0]                r_last_op;
  logic                      r_out_valid;
  logic                      w_full;
  logic                      w_empty;
  logic                      w_wr_ok;
  logic                      w_rd_ok;
  logic [1:0]                w_op;
  logic [GW-1:0]             w_grant;
  logic                      w_fifo_wr;
  logic                      w_fifo_rd;
  logic [NUM_REQ-1:0]        w_req_ready;
  logic [ITEM_SIZE_BITS-1:0] w_data_in;
  logic [LW-1:0]             w_count;

  // Reset gates eligibility so no strobe or ready escapes while RST_N is low.
  assign w_wr_ok = RST_N && (|req_valid) && !w_full;
  assign w_rd_ok = RST_N && !w_empty && (!r_out_valid || out_ready);
  assign w_grant = GW'(rr_pick(MAX_REQ'(req_valid), 32'(r_rr_ptr), NUM_REQ));

  always_comb begin
    w_op = OP_NONE;
    if (w_wr_ok && w_rd_ok) w_op = (r_last_op == OP_WRITE) ? OP_READ : OP_WRITE;
    else if (w_wr_ok)       w_op = OP_WRITE;
    else if (w_rd_ok)       w_op = OP_READ;
  end

  always_comb begin
    w_req_ready = '0;
    if (w_op == OP_WRITE) w_req_ready[w_grant] = 1'b1;
  end

  assign w_fifo_wr  = (w_op == OP_WRITE);
  assign w_fifo_rd  = (w_op == OP_READ);
  assign w_data_in  = req_data[w_grant*ITEM_SIZE_BITS +: ITEM_SIZE_BITS];
  assign req_ready  = w_req_ready;
  assign out_valid  = r_out_valid;
  assign level      = w_count;
  assign last_grant = r_last_grant;

  always_ff @(posedge CLOCK_50) begin
    if (!RST_N) begin
      r_rr_ptr     <= GW'(NUM_REQ - 1);
      r_last_grant <= '0;
      r_last_op    <= OP_READ;
      r_out_valid  <= 1'b0;
    end else begin
      if (w_fifo_wr) begin
        r_rr_ptr     <= w_grant;
        r_last_grant <= w_grant;
        r_last_op    <= OP_WRITE;
      end
      if (w_fifo_rd) begin
        r_last_op   <= OP_READ;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  fifo #(
    .ITEM_SIZE_BITS(ITEM_SIZE_BITS),
    .FIFO_SIZE     (FIFO_SIZE)
  ) u_fifo (
    .CLOCK_50(CLOCK_50),
    .RST_N   (RST_N),
    .write   (w_fifo_wr),
    .read    (w_fifo_rd),
    .data_in (w_data_in),
    .data_out(out_data),
    .full    (w_full),
    .empty   (w_empty),
    .count   (w_count)
  );

  a_single_op: assert property (@(posedge CLOCK_50) !(w_fifo_wr && w_fifo_rd));

endmodule

// File: tb/tb_fifo_arbiter.sv
// Scoreboard bench for fifo_arbiter: a queue-based reference model predicts
// grants and occupancy; a separate monitor checks the output item stream.
module tb_fifo_arbiter;
  localparam int W  = 32;
  localparam int FS = 10;
  localparam int NR = 4;

  logic              CLOCK_50 = 1'b0;
  logic              RST_N = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*W-1:0]   req_data = '0;
  logic [NR-1:0]     req_ready;
  logic              out_valid;
  logic [W-1:0]      out_data;
  logic              out_ready = 1'b0;
  logic [3:0]        level;
  logic [1:0]        last_grant;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q[$];
  int           m_cnt = 0;
  bit           m_out_valid = 1'b0;
  int           m_rr = NR - 1;
  int           m_last_grant = 0;
  bit           m_last_write = 1'b0;

  fifo_arbiter #(.ITEM_SIZE_BITS(W), .FIFO_SIZE(FS), .NUM_REQ(NR)) dut (
    .CLOCK_50  (CLOCK_50),
    .RST_N     (RST_N),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .level     (level),
    .last_grant(last_grant)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  function automatic void chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endfunction

  // Reference model: evaluated mid-cycle on stable inputs, then advanced to
  // the state the design should hold after the coming rising edge.
  always @(negedge CLOCK_50) begin
    logic [NR-1:0] e_ready;
    bit wr_ok, rd_ok, do_wr, do_rd;
    int g;
    if (!RST_N) begin
      chk("reset_req_ready", W'(req_ready), '0);
      exp_q.delete();
      m_cnt = 0;
      m_out_valid = 1'b0;
      m_rr = NR - 1;
      m_last_grant = 0;
      m_last_write = 1'b0;
    end else begin
      chk("level", W'(level), W'(m_cnt));
      chk("out_valid", W'(out_valid), W'(m_out_valid));
      chk("last_grant", W'(last_grant), W'(m_last_grant));
      wr_ok = (req_valid != '0) && (m_cnt < FS);
      rd_ok = (m_cnt > 0) && (!m_out_valid || out_ready);
      do_wr = wr_ok && (!rd_ok || !m_last_write);
      do_rd = rd_ok && !do_wr;
      e_ready = '0;
      g = 0;
      if (do_wr) begin
        for (int k = NR; k >= 1; k--)
          if (req_valid[(m_rr + k) % NR]) g = (m_rr + k) % NR;
        e_ready[g] = 1'b1;
        exp_q.push_back(req_data[g*W +: W]);
        m_cnt++;
        m_rr = g;
        m_last_grant = g;
        m_last_write = 1'b1;
      end
      chk("req_ready", W'(req_ready), W'(e_ready));
      if (do_rd) begin
        m_cnt--;
        m_out_valid = 1'b1;
        m_last_write = 1'b0;
      end else if (m_out_valid && out_ready) begin
        m_out_valid = 1'b0;
      end
    end
  end

  // Monitor: the presented item must be the oldest accepted, unconsumed write.
  always @(negedge CLOCK_50) begin
    if (RST_N && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_data unexpected item actual=%h required=none at %0t", out_data, $time);
      end else begin
        chk("out_data", out_data, exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic drive(input logic [NR-1:0] v, input logic ordy, input int n);
    repeat (n) begin
      req_valid = v;
      out_ready = ordy;
      for (int i = 0; i < NR; i++) req_data[i*W +: W] = $urandom;
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    RST_N = 1'b0;
    drive(NR'($urandom), 1'($urandom), n);
    RST_N = 1'b1;
  endtask

  initial begin
    do_reset(3);

    // Single write from writer 0, read out with the consumer ready.
    req_valid = 4'b0001;
    out_ready = 1'b1;
    req_data  = '0;
    req_data[W-1:0] = 32'hA5A5_0001;
    #8;
    chk("t1_first_grant", W'(req_ready), W'(4'b0001));
    @(posedge CLOCK_50);
    #1;
    drive('0, 1'b1, 1);
    chk("t1_out_valid", W'(out_valid), W'(1));
    chk("t1_out_data", out_data, 32'hA5A5_0001);
    drive('0, 1'b1, 3);
    chk("t1_level", W'(level), '0);

    // Round-robin fill with the consumer stalled, then full boundary.
    do_reset(1);
    drive(4'hF, 1'b0, 16);
    chk("rr_full_level", W'(level), W'(FS));
    drive(4'b0010, 1'b0, 3);
    drive(4'b0010, 1'b1, 1);
    drive(4'b0010, 1'b0, 2);
    chk("full_regrant_level", W'(level), W'(FS));
    chk("full_regrant_last", W'(last_grant), W'(1));

    // Backpressure on a non-empty FIFO, then release.
    drive('0, 1'b0, 5);
    drive('0, 1'b1, 1);
    drive('0, 1'b0, 2);

    // Contention between writers 0/2 and the reader.
    do_reset(1);
    drive(4'b0001, 1'b0, 4);
    drive(4'b0101, 1'b1, 14);

    // Reset in the middle of activity.
    do_reset(1);
    drive(4'hF, 1'b0, 8);
    do_reset(1);
    chk("midrst_level", W'(level), '0);
    chk("midrst_out_valid", W'(out_valid), '0);
    drive(4'hF, 1'b0, 1);
    chk("midrst_first_grant", W'(last_grant), '0);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) do_reset(1);
      else drive(NR'($urandom), ($urandom_range(0, 3) != 0), 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
